main_mem_banked: RTL and testbench

- Parametrised next-generation main memory for the matrix CPU datapath.
- Adds configurable width, depth and read latency, a Busy/DataValid handshake, 16-bit lane write enables (one lane per matrix element), and an error flag for bad requests.
- Sits on the shared CPU bus and responds only when the address select field matches MEM_SEL.

---
 rtl/main_mem_banked.sv | 135 +++++++++++++
 tb/tb_main_mem_banked.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_banked.sv
// Banked main memory for the matrix CPU datapath: lane-masked writes, fixed-latency reads,
// Busy/DataValid handshake and an Error pulse for malformed or out-of-range requests.
module main_mem_banked #(
    parameter int                  DATA_W   = 256,
    parameter int                  DEPTH    = 12,
    parameter int                  ADDR_W   = 16,
    parameter int                  SEL_W    = 4,
    parameter logic [SEL_W-1:0]    MEM_SEL  = '0,
    parameter int                  READ_LAT = 2,
    parameter logic [DATA_W-1:0]   INIT0    = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010,
    parameter logic [DATA_W-1:0]   INIT1    = 256'h0020_001f_001e_001d_001c_001b_001a_0019_0018_0017_0016_0015_0014_0013_0012_0011,
    parameter int                  LANES    = DATA_W / 16
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic [ADDR_W-1:0]      Address,
    input  logic [DATA_W-1:0]      DataIn,
    input  logic [LANES-1:0]       LaneEn,
    input  logic                   nRead,
    input  logic                   nWrite,
    output logic [DATA_W-1:0]      Dataout,
    output logic                   DataValid,
    output logic                   WriteAck,
    output logic                   Busy,
    output logic                   Error
);

    localparam int IW    = ADDR_W - SEL_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   rd_idx, rd_idx_d;
    logic               busy_d, valid_d, ack_d, err_d, load_out, wr_en;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [IW-1:0]      idx;
    logic [IDX_W-1:0]   idx_short;
    logic               sel_hit, in_range;

    assign idx       = Address[IW-1:0];
    assign idx_short = IDX_W'(idx);
    assign sel_hit   = (Address[ADDR_W-1 -: SEL_W] == MEM_SEL);
    assign in_range  = (32'(idx) < DEPTH);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rd_idx_d = rd_idx;
        busy_d   = Busy;
        valid_d  = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        load_out = 1'b0;
        wr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_hit) begin
                    if (!nRead && !nWrite) begin
                        err_d = 1'b1;
                    end else if (!nRead || !nWrite) begin
                        if (!in_range) begin
                            err_d = 1'b1;
                        end else if (!nRead) begin
                            rd_idx_d = idx_short;
                            cnt_d    = CNT_W'(READ_LAT - 1);
                            busy_d   = 1'b1;
                            state_d  = (READ_LAT == 1) ? RD_DONE : RD_WAIT;
                        end else begin
                            wr_en = 1'b1;
                            ack_d = 1'b1;
                        end
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_d = RD_DONE;
            end
            RD_DONE: begin
                // Requests seen on this edge are still ignored; the next IDLE edge may accept.
                load_out = 1'b1;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_idx    <= '0;
            Dataout   <= '0;
            DataValid <= 1'b0;
            WriteAck  <= 1'b0;
            Busy      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rd_idx    <= rd_idx_d;
            DataValid <= valid_d;
            WriteAck  <= ack_d;
            Busy      <= busy_d;
            Error     <= err_d;
            if (load_out) Dataout <= mem[rd_idx];
        end
    end

    // NOTE: the array is deliberately reset because words 0 and 1 carry boot contents; this
    // keeps it in flops rather than a RAM macro, which is acceptable at this depth.
    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= (w == 0) ? INIT0 : (w == 1) ? INIT1 : '0;
            end
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (LaneEn[l]) mem[idx_short][16*l +: 16] <= DataIn[16*l +: 16];
            end
        end
    end

endmodule

// File: tb/tb_main_mem_banked.sv
// Self-checking bench for main_mem_banked: directed scenarios followed by randomized traffic
// compared against a word-array reference model with spec-level read latency.
module tb_main_mem_banked #(
    parameter int LAT = 2
);

    localparam int DW    = 256;
    localparam int DEPTH = 12;
    localparam int AW    = 16;
    localparam int IW    = 12;
    localparam int LN    = DW / 16;
    localparam logic [3:0] SEL = 4'h0;

    logic            Clk = 1'b0;
    logic            nReset;
    logic [AW-1:0]   Address;
    logic [DW-1:0]   DataIn;
    logic [LN-1:0]   LaneEn;
    logic            nRead, nWrite;
    logic [DW-1:0]   Dataout;
    logic            DataValid, WriteAck, Busy, Error;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_dout;

    main_mem_banked #(.READ_LAT(LAT)) dut (
        .Clk(Clk), .nReset(nReset), .Address(Address), .DataIn(DataIn), .LaneEn(LaneEn),
        .nRead(nRead), .nWrite(nWrite), .Dataout(Dataout), .DataValid(DataValid),
        .WriteAck(WriteAck), .Busy(Busy), .Error(Error)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // DUT state changes on the falling edge; inputs and samples move 1 time unit after it.
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_mask(input logic [LN-1:0] lanes);
        logic [DW-1:0] m = '0;
        for (int i = 0; i < LN; i++) if (lanes[i]) m[16*i +: 16] = 16'hFFFF;
        return m;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [3:0] sel, input int idx);
        return {sel, IW'(idx)};
    endfunction

    task automatic model_reset();
        for (int w = 0; w < DEPTH; w++) model_mem[w] = '0;
        for (int i = 0; i < LN; i++) begin
            model_mem[0][16*i +: 16] = 16'(16 - i);
            model_mem[1][16*i +: 16] = 16'(16'h11 + i);
        end
        model_dout = '0;
    endtask

    task automatic do_write(input int idx, input logic [DW-1:0] d, input logic [LN-1:0] lanes);
        logic [DW-1:0] m;
        Address = addr_of(SEL, idx); DataIn = d; LaneEn = lanes; nWrite = 1'b0;
        tick();
        nWrite = 1'b1;
        check("wr_ack", WriteAck, 1'b1);
        check("wr_err", Error, 1'b0);
        m = lane_mask(lanes);
        model_mem[idx] = (model_mem[idx] & ~m) | (d & m);
    endtask

    task automatic do_read(input int idx, input string tag);
        Address = addr_of(SEL, idx); nRead = 1'b0;
        tick();
        nRead = 1'b1;
        check({tag, "_busy_acc"}, Busy, 1'b1);
        check({tag, "_ack_acc"}, WriteAck, 1'b0);
        for (int k = 1; k < LAT; k++) begin
            tick();
            check({tag, "_busy_wait"}, Busy, 1'b1);
            check({tag, "_dv_early"}, DataValid, 1'b0);
        end
        tick();
        model_dout = model_mem[idx];
        check({tag, "_busy_done"}, Busy, 1'b0);
        check({tag, "_dv"}, DataValid, 1'b1);
        check({tag, "_data"}, Dataout, model_dout);
        tick();
        check({tag, "_dv_pulse"}, DataValid, 1'b0);
        check({tag, "_data_hold"}, Dataout, model_dout);
    endtask

    task automatic do_bad(input logic [AW-1:0] addr, input logic rd, input logic wr, input string tag);
        Address = addr; DataIn = rand_word(); LaneEn = '1; nRead = rd; nWrite = wr;
        tick();
        nRead = 1'b1; nWrite = 1'b1;
        check({tag, "_err"}, Error, 1'b1);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_ack"}, WriteAck, 1'b0);
        tick();
        check({tag, "_err_pulse"}, Error, 1'b0);
        check({tag, "_dv"}, DataValid, 1'b0);
        check({tag, "_dout"}, Dataout, model_dout);
    endtask

    task automatic do_miss(input int idx, input logic is_wr);
        Address = addr_of(4'h1, idx); DataIn = rand_word(); LaneEn = '1;
        nRead = is_wr; nWrite = !is_wr;
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            check("miss_busy", Busy, 1'b0);
            check("miss_dv", DataValid, 1'b0);
            check("miss_err", Error, 1'b0);
            check("miss_ack", WriteAck, 1'b0);
        end
        nRead = 1'b1; nWrite = 1'b1;
    endtask

    initial begin
        int n;
        logic [DW-1:0] d;
        nReset = 1'b0; nRead = 1'b1; nWrite = 1'b1;
        Address = '0; DataIn = '0; LaneEn = '0;
        model_reset();
        #3;
        check("rst_dout", Dataout, '0);
        check("rst_dv", DataValid, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_err", Error, 1'b0);
        check("rst_ack", WriteAck, 1'b0);
        tick();
        nReset = 1'b1;

        // Boot contents and read latency
        do_read(0, "rd_init0");
        do_read(1, "rd_init1");

        // Lane-masked write
        do_write(5, '1, 16'h00F0);
        tick();
        check("wr_ack_pulse", WriteAck, 1'b0);
        do_read(5, "rd_lanes");
        check("lanes_const", Dataout, {128'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        // Rejected requests
        do_bad(addr_of(SEL, DEPTH), 1'b0, 1'b1, "bad_idx_rd");
        do_bad(addr_of(SEL, 4), 1'b0, 1'b0, "both_low");
        do_bad(addr_of(SEL, DEPTH + 3), 1'b1, 1'b0, "bad_idx_wr");
        do_read(4, "rd_after_bad");
        do_miss(0, 1'b0);
        do_miss(6, 1'b1);
        do_read(6, "rd_after_miss");

        // Write held while a read is in flight
        d = rand_word();
        Address = addr_of(SEL, 1); nRead = 1'b0;
        tick();
        nRead = 1'b1;
        Address = addr_of(SEL, 3); DataIn = d; LaneEn = '1; nWrite = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            check("busy_ign_ack", WriteAck, 1'b0);
            check("busy_ign_err", Error, 1'b0);
            tick();
            n++;
        end
        check("busy_len", 32'(n), 32'(LAT));
        model_dout = model_mem[1];
        check("busy_rd_dv", DataValid, 1'b1);
        check("busy_rd_data", Dataout, model_dout);
        tick();
        nWrite = 1'b1;
        check("held_wr_ack", WriteAck, 1'b1);
        model_mem[3] = d;
        do_read(3, "rd_held");

        // Reset during an in-flight read
        do_write(2, 256'hABCD, '1);
        Address = addr_of(SEL, 2); nRead = 1'b0;
        tick();
        nRead = 1'b1;
        check("rst_mid_busy", Busy, 1'b1);
        #2 nReset = 1'b0;
        #1;
        check("rst_mid_busy0", Busy, 1'b0);
        check("rst_mid_dout", Dataout, '0);
        check("rst_mid_dv", DataValid, 1'b0);
        tick();
        nReset = 1'b1;
        model_reset();
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            check("rst_mid_no_dv", DataValid, 1'b0);
            check("rst_mid_idle", Busy, 1'b0);
        end
        do_read(2, "rd_after_rst2");
        do_read(3, "rd_after_rst3");
        do_read(0, "rd_after_rst0");

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            int op, idx;
            op  = $urandom_range(0, 8);
            idx = $urandom_range(0, DEPTH - 1);
            case (op)
                0, 1, 2: do_write(idx, rand_word(), LN'($urandom));
                3, 4, 5: do_read(idx, "rnd_rd");
                6:       do_bad(addr_of(SEL, $urandom_range(DEPTH, DEPTH + 40)), 1'b0, 1'b1, "rnd_bad");
                7:       do_bad(addr_of(SEL, idx), 1'b0, 1'b0, "rnd_both");
                default: do_miss(idx, 1'($urandom));
            endcase
        end
        for (int w = 0; w < DEPTH; w++) do_read(w, "sweep");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
